measure_speed_window: RTL and testbench

MEASURE_SPEED_WINDOW -- requirements
Module: measure_speed_window

---
 rtl/measure_speed_pkg.sv | 11 +
 rtl/window_timer.sv | 36 +++
 rtl/measure_speed_window.sv | 136 +++++++++++++
 tb/tb_measure_speed_window.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/measure_speed_pkg.sv
// rtl/measure_speed_pkg.sv - shared widths, filter depth and FSM states for measure_speed_window
package measure_speed_pkg;
    localparam int COUNT_W   = 16;
    localparam int SPEED_W   = 16;
    localparam int FILT_TAPS = 4;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;
endpackage

// File: rtl/window_timer.sv
// rtl/window_timer.sv - free-running measurement window timer, tick on the last cycle of each window
module window_timer #(
    parameter int SAMPLE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam logic [23:0] LAST = 24'(SAMPLE_CYCLES - 1);

    logic [23:0] count_q;
    logic [23:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!en) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + 24'd1;
        end
    end

    // Gating with en means a tick coinciding with en falling is simply never seen.
    assign tick = en && (count_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/measure_speed_window.sv
// rtl/measure_speed_window.sv - per-window signed speed, direction and stop detect from a wrapping count
// Optional 4-tap moving-average of speed when MEASURE_SPEED_FILTER_EN is defined.
module measure_speed_window
    import measure_speed_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 50000,
    parameter int STOP_WINDOWS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [COUNT_W-1:0]   enc_count,
    output logic [SPEED_W-1:0]   speed,
    output logic                 speed_valid,
    output logic                 dir,
    output logic                 stopped
);
    localparam logic [7:0] STOP_N = 8'(STOP_WINDOWS);

    logic tick;

    window_timer #(
        .SAMPLE_CYCLES(SAMPLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] prev_q, prev_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               valid_q, valid_d;
    logic               dir_q, dir_d;
    logic [7:0]         zrun_q, zrun_d;
    logic               stopped_q, stopped_d;

    // Modulo subtraction makes counter wrap transparent.
    logic [COUNT_W-1:0] delta;
    assign delta = enc_count - prev_q;

    logic [SPEED_W-1:0] speed_new;

`ifdef MEASURE_SPEED_FILTER_EN
    logic [FILT_TAPS-2:0][SPEED_W-1:0] hist_q, hist_d;
    logic [SPEED_W+1:0]                filt_sum;

    always_comb begin
        filt_sum = {{2{delta[SPEED_W-1]}}, delta};
        for (int i = 0; i < FILT_TAPS - 1; i++) begin
            filt_sum = filt_sum + {{2{hist_q[i][SPEED_W-1]}}, hist_q[i]};
        end
    end

    // Dropping the two LSBs of the sign-extended sum is an arithmetic shift toward -inf.
    assign speed_new = filt_sum[SPEED_W+1:2];

    always_comb begin
        hist_d = hist_q;
        if (!en || state_q == PRIME) begin
            hist_d = '0;
        end else if (tick) begin
            hist_d = {hist_q[FILT_TAPS-3:0], delta};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign speed_new = delta;
`endif

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        speed_d   = speed_q;
        valid_d   = 1'b0;
        dir_d     = dir_q;
        zrun_d    = zrun_q;
        stopped_d = stopped_q;
        if (!en) begin
            state_d = PRIME;
        end else if (tick) begin
            prev_d = enc_count;
            case (state_q)
                PRIME: begin
                    state_d = RUN;
                end
                RUN: begin
                    valid_d = 1'b1;
                    speed_d = speed_new;
                    // Direction and stop detect follow the raw delta, never the filtered value.
                    if (delta != '0) begin
                        dir_d  = delta[COUNT_W-1];
                        zrun_d = '0;
                    end else if (zrun_q != STOP_N) begin
                        zrun_d = zrun_q + 8'd1;
                    end
                    stopped_d = (zrun_d == STOP_N);
                end
                default: state_d = PRIME;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PRIME;
            prev_q    <= '0;
            speed_q   <= '0;
            valid_q   <= 1'b0;
            dir_q     <= 1'b0;
            zrun_q    <= '0;
            stopped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            speed_q   <= speed_d;
            valid_q   <= valid_d;
            dir_q     <= dir_d;
            zrun_q    <= zrun_d;
            stopped_q <= stopped_d;
        end
    end

    assign speed       = speed_q;
    assign speed_valid = valid_q;
    assign dir         = dir_q;
    assign stopped     = stopped_q;
endmodule

// File: tb/tb_measure_speed_window.sv
// tb/tb_measure_speed_window.sv - directed self-checking bench for measure_speed_window
module tb_measure_speed_window;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] enc_count = 16'h0000;
    logic [15:0] speed;
    logic        speed_valid;
    logic        dir;
    logic        stopped;

    int err_cnt = 0;
    int chk_cnt = 0;
    bit ramp = 1'b0;
    int phase = 0;
    int vcount = 0;

    measure_speed_window #(
        .SAMPLE_CYCLES(100),
        .STOP_WINDOWS (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .enc_count   (enc_count),
        .speed       (speed),
        .speed_valid (speed_valid),
        .dir         (dir),
        .stopped     (stopped)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (speed_valid) vcount++;
        if (ramp) begin
            phase++;
            if (phase == 10) begin
                phase = 0;
                enc_count = enc_count + 16'd1;
            end
        end
    endtask

    task automatic wait_valid(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!speed_valid && n < exp_n + 20);
        check_val({tag, "_lat"}, n, exp_n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_speed", speed, 16'h0000);
        check_val("rst_valid", speed_valid, 1'b0);
        check_val("rst_dir", dir, 1'b0);
        check_val("rst_stopped", stopped, 1'b0);
        reset = 1'b0;
        en = 1'b1;

`ifndef MEASURE_SPEED_FILTER_EN
        ramp = 1'b1;
        wait_valid("first", 200);
        check_val("ramp1_speed", speed, 16'd10);
        check_val("ramp1_dir", dir, 1'b0);
        check_val("ramp1_stopped", stopped, 1'b0);
        step();
        check_val("valid_one_cycle", speed_valid, 1'b0);
        wait_valid("ramp2", 99);
        check_val("ramp2_speed", speed, 16'd10);

        ramp = 1'b0;
        enc_count = 16'hFFF0;
        wait_valid("wrap_pre", 100);
        enc_count = 16'h0010;
        wait_valid("wrap_fwd", 100);
        check_val("wrap_fwd_speed", speed, 16'd32);
        check_val("wrap_fwd_dir", dir, 1'b0);
        enc_count = 16'hFFF0;
        wait_valid("wrap_rev", 100);
        check_val("wrap_rev_speed", speed, 16'hFFE0);
        check_val("wrap_rev_dir", dir, 1'b1);

        wait_valid("zero1", 100);
        check_val("zero1_speed", speed, 16'h0000);
        check_val("zero1_stopped", stopped, 1'b0);
        wait_valid("zero2", 100);
        check_val("zero2_stopped", stopped, 1'b0);
        wait_valid("zero3", 100);
        check_val("zero3_stopped", stopped, 1'b1);
        check_val("zero3_dir_hold", dir, 1'b1);
        enc_count = 16'hFFF1;
        wait_valid("unstop", 100);
        check_val("unstop_speed", speed, 16'd1);
        check_val("unstop_stopped", stopped, 1'b0);
        check_val("unstop_dir", dir, 1'b0);

        ramp = 1'b1;
        repeat (30) step();
        en = 1'b0;
        vcount = 0;
        repeat (250) step();
        check_val("en_low_valids", vcount, 0);
        en = 1'b1;
        wait_valid("en_resume", 200);
        check_val("en_resume_speed", speed, 16'd10);

        repeat (50) step();
        reset = 1'b1;
        #1;
        check_val("arst_speed", speed, 16'h0000);
        check_val("arst_valid", speed_valid, 1'b0);
        check_val("arst_dir", dir, 1'b0);
        check_val("arst_stopped", stopped, 1'b0);
        repeat (2) step();
        reset = 1'b0;
        wait_valid("arst_restart", 200);
        check_val("arst_restart_speed", speed, 16'd10);
`else
        ramp = 1'b0;
        wait_valid("filt_prime", 200);
        check_val("filt_zero_speed", speed, 16'h0000);
        enc_count = 16'd8;
        wait_valid("filt_p1", 100);
        check_val("filt_p1_speed", speed, 16'd2);
        enc_count = 16'd16;
        wait_valid("filt_p2", 100);
        check_val("filt_p2_speed", speed, 16'd4);
        enc_count = 16'd24;
        wait_valid("filt_p3", 100);
        check_val("filt_p3_speed", speed, 16'd6);
        enc_count = 16'd32;
        wait_valid("filt_p4", 100);
        check_val("filt_p4_speed", speed, 16'd8);
        check_val("filt_p4_dir", dir, 1'b0);

        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        wait_valid("filt_reprime", 200);
        check_val("filt_cleared_speed", speed, 16'h0000);
        enc_count = 16'd31;
        wait_valid("filt_n1", 100);
        check_val("filt_n1_speed", speed, 16'hFFFF);
        check_val("filt_n1_dir", dir, 1'b1);
        enc_count = 16'd30;
        wait_valid("filt_n2", 100);
        check_val("filt_n2_speed", speed, 16'hFFFF);
        enc_count = 16'd29;
        wait_valid("filt_n3", 100);
        check_val("filt_n3_speed", speed, 16'hFFFF);
        enc_count = 16'd28;
        wait_valid("filt_n4", 100);
        check_val("filt_n4_speed", speed, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
